chess_board_renderer: RTL and testbench

Parametrised per-pixel renderer for the full 8x8 chess board. It takes DrawX/DrawY from the VGA controller and holds a 64-entry board-state register file of piece codes. It addresses one shared multi-sprite ROM and resolves the pixel colour through an external palette. Checkerboard squares, sprite transparency and cursor/selection highlight borders are composited here. A 3-stage pipeline drives red/green/blue.

---
 rtl/chess_board_renderer_if.sv | 54 +++++
 rtl/chess_board_renderer.sv | 183 ++++++++++++++++++
 tb/tb_chess_board_renderer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chess_board_renderer_if.sv
// rtl/chess_board_renderer_if.sv - pixel, board-edit, sprite-ROM/palette and colour signals of the chess board renderer
//
// Purpose: groups every non-clock signal of chess_board_renderer.
//   slave  : the renderer's view (pixel/edit/ROM-data/palette in; ROM address, palette index and colour out)
//   master : the environment's view (VGA controller, game logic, sprite ROM, palette)
// Signals:
//   DrawX, DrawY    current pixel column/row
//   blank           1 = visible region, 0 = force black
//   wr_en/wr_sq/wr_piece, clr_board   board edits
//   cursor_sq, sel_valid, sel_sq      highlight squares
//   rom_addr/rom_q  sprite ROM address and palette-index data
//   pal_idx/pal_rgb palette index and resolved {r,g,b}
//   red/green/blue  registered pixel colour
`timescale 1ns/1ps
interface chess_board_renderer_if #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              wr_en;
  logic [5:0]        wr_sq;
  logic [3:0]        wr_piece;
  logic              clr_board;
  logic [5:0]        cursor_sq;
  logic              sel_valid;
  logic [5:0]        sel_sq;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_idx;
  logic [11:0]       pal_rgb;
  logic [3:0]        red;
  logic [3:0]        green;
  logic [3:0]        blue;

  modport slave (
    input  DrawX, DrawY, blank,
    input  wr_en, wr_sq, wr_piece, clr_board,
    input  cursor_sq, sel_valid, sel_sq,
    input  rom_q, pal_rgb,
    output rom_addr, pal_idx,
    output red, green, blue
  );

  modport master (
    output DrawX, DrawY, blank,
    output wr_en, wr_sq, wr_piece, clr_board,
    output cursor_sq, sel_valid, sel_sq,
    output rom_q, pal_rgb,
    input  rom_addr, pal_idx,
    input  red, green, blue
  );
endinterface

// File: rtl/chess_board_renderer.sv
// rtl/chess_board_renderer.sv - 3-stage per-pixel renderer for an 8x8 chess board with sprites and highlights
//
// Purpose: holds the 64-square board state, maps each VGA pixel to a square and
// sprite texel, fetches the texel's palette index from a shared sprite ROM and
// composites checkerboard, sprite (with transparency), cursor and selection
// borders into a registered 4:4:4 colour.
// Ports:
//   vga_clk  pixel clock, all state on posedge
//   reset    synchronous, active-high; reloads the start position and flushes the pipeline
//   bus      chess_board_renderer_if.slave (pixel, board edits, highlights, ROM, palette, colour)
// Pipeline: pixel sampled at edge k -> rom_addr at k, pal_idx at k+1, red/green/blue at k+2.
`timescale 1ns/1ps
module chess_board_renderer #(
  parameter int          SQUARE          = 60,
  parameter int          BOARD_X0        = 80,
  parameter int          BOARD_Y0        = 0,
  parameter int          IDX_W           = 4,
  parameter int          ADDR_W          = 16,
  parameter int          TRANSPARENT_IDX = 0,
  parameter int          BORDER          = 2,
  parameter logic [11:0] LIGHT_RGB       = 12'hEED,
  parameter logic [11:0] DARK_RGB        = 12'h785,
  parameter logic [11:0] BG_RGB          = 12'h222,
  parameter logic [11:0] CURSOR_RGB      = 12'hFF0,
  parameter logic [11:0] SEL_RGB         = 12'h0F0
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  chess_board_renderer_if.slave  bus
);

  localparam logic [9:0]        X0      = 10'(BOARD_X0);
  localparam logic [9:0]        Y0      = 10'(BOARD_Y0);
  // Board span; the board must end at or before column/row 1023 so that a
  // pixel left of/above the board wraps dx/dy past the span.
  localparam logic [9:0]        SPAN    = 10'(8 * SQUARE);
  localparam logic [9:0]        SQ_W    = 10'(SQUARE);
  localparam logic [9:0]        BRD_LO  = 10'(BORDER);
  localparam logic [9:0]        BRD_HI  = 10'(SQUARE - BORDER);
  localparam logic [ADDR_W-1:0] SQ_AREA = ADDR_W'(SQUARE * SQUARE);
  localparam logic [ADDR_W-1:0] SQ_ROW  = ADDR_W'(SQUARE);
  localparam logic [IDX_W-1:0]  T_IDX   = IDX_W'(TRANSPARENT_IDX);

  // White back rank R N B Q K B N R; black pieces are the white code + 6.
  function automatic logic [3:0] back_rank(input logic [2:0] c);
    case (c)
      3'd0, 3'd7: back_rank = 4'd4;
      3'd1, 3'd6: back_rank = 4'd2;
      3'd2, 3'd5: back_rank = 4'd3;
      3'd3:       back_rank = 4'd5;
      default:    back_rank = 4'd6;
    endcase
  endfunction

  function automatic logic [3:0] start_piece(input logic [5:0] sq);
    case (sq[5:3])
      3'd0:    start_piece = back_rank(sq[2:0]) + 4'd6;
      3'd1:    start_piece = 4'd7;
      3'd6:    start_piece = 4'd1;
      3'd7:    start_piece = back_rank(sq[2:0]);
      default: start_piece = 4'd0;
    endcase
  endfunction

  typedef struct packed {
    logic vis;       // blank input (1 = visible)
    logic on_board;
    logic piece;     // square holds a piece
    logic dark;
    logic cursor;    // cursor border pixel
    logic sel;       // selection border pixel
  } flags_t;

  logic [63:0][3:0]  start_board;
  logic [63:0][3:0]  board_q, board_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [IDX_W-1:0]  pal_idx_q, pal_idx_d;
  flags_t            flags_s0_q, flags_s0_d;
  flags_t            flags_s1_q, flags_s1_d;
  logic [11:0]       rgb_q, rgb_d;

  always_comb begin
    start_board = '0;
    for (int i = 0; i < 64; i++) begin
      start_board[i] = start_piece(6'(i));
    end
  end

  // Board edits: clear wins over a write in the same cycle; codes above 12 are dropped.
  always_comb begin
    board_d = board_q;
    if (bus.clr_board) begin
      board_d = start_board;
    end else if (bus.wr_en && (bus.wr_piece <= 4'd12)) begin
      board_d[bus.wr_sq] = bus.wr_piece;
    end
  end

  // Stage 0: pixel -> square/texel, board read from registered state only.
  logic [9:0] dx, dy, sx, sy;
  logic [2:0] col, row;
  logic [5:0] sq;
  logic [3:0] piece;
  logic       on_board, edge_px, has_piece;

  always_comb begin
    // Unsigned wrap makes pixels before the board origin land beyond SPAN.
    dx        = bus.DrawX - X0;
    dy        = bus.DrawY - Y0;
    on_board  = (dx < SPAN) && (dy < SPAN);
    col       = 3'(dx / SQ_W);
    row       = 3'(dy / SQ_W);
    sx        = dx % SQ_W;
    sy        = dy % SQ_W;
    sq        = {row, col};
    piece     = board_q[sq];
    has_piece = on_board && (piece != 4'd0);
    edge_px   = (sx < BRD_LO) || (sx >= BRD_HI) || (sy < BRD_LO) || (sy >= BRD_HI);

    rom_addr_d = '0;
    if (has_piece) begin
      rom_addr_d = ADDR_W'(piece - 4'd1) * SQ_AREA + ADDR_W'(sy) * SQ_ROW + ADDR_W'(sx);
    end

    flags_s0_d.vis      = bus.blank;
    flags_s0_d.on_board = on_board;
    flags_s0_d.piece    = has_piece;
    flags_s0_d.dark     = row[0] ^ col[0];
    flags_s0_d.cursor   = on_board && edge_px && (sq == bus.cursor_sq);
    flags_s0_d.sel      = on_board && edge_px && bus.sel_valid && (sq == bus.sel_sq);
  end

  // Stage 1: capture the ROM texel; flags follow.
  always_comb begin
    pal_idx_d  = bus.rom_q;
    flags_s1_d = flags_s0_q;
  end

  // Stage 2: colour select, highest priority first.
  always_comb begin
    rgb_d = 12'h000;
    if (!flags_s1_q.vis) begin
      rgb_d = 12'h000;
    end else if (!flags_s1_q.on_board) begin
      rgb_d = BG_RGB;
    end else if (flags_s1_q.cursor) begin
      rgb_d = CURSOR_RGB;
    end else if (flags_s1_q.sel) begin
      rgb_d = SEL_RGB;
    end else if (flags_s1_q.piece && (pal_idx_q != T_IDX)) begin
      rgb_d = bus.pal_rgb;
    end else if (flags_s1_q.dark) begin
      rgb_d = DARK_RGB;
    end else begin
      rgb_d = LIGHT_RGB;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      board_q    <= start_board;
      rom_addr_q <= '0;
      pal_idx_q  <= '0;
      flags_s0_q <= '0;
      flags_s1_q <= '0;
      rgb_q      <= '0;
    end else begin
      board_q    <= board_d;
      rom_addr_q <= rom_addr_d;
      pal_idx_q  <= pal_idx_d;
      flags_s0_q <= flags_s0_d;
      flags_s1_q <= flags_s1_d;
      rgb_q      <= rgb_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.pal_idx  = pal_idx_q;
  assign bus.red      = rgb_q[11:8];
  assign bus.green    = rgb_q[7:4];
  assign bus.blue     = rgb_q[3:0];

endmodule

// File: tb/tb_chess_board_renderer.sv
// tb/tb_chess_board_renderer.sv - directed and randomized self-checking bench for chess_board_renderer
`timescale 1ns/1ps
module tb_chess_board_renderer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chess_board_renderer_if bus ();

  chess_board_renderer dut (
    .vga_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  // External sprite ROM (asynchronous read) and palette.
  logic [3:0]  rom_mem [65536];
  logic [11:0] pal_mem [16];
  assign bus.rom_q   = rom_mem[bus.rom_addr];
  assign bus.pal_rgb = pal_mem[bus.pal_idx];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference board model.
  int mb [64];

  task automatic model_reset();
    int back [8];
    back = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int i = 0; i < 64; i++) mb[i] = 0;
    for (int c = 0; c < 8; c++) begin
      mb[c]      = back[c] + 6;
      mb[8 + c]  = 7;
      mb[48 + c] = 1;
      mb[56 + c] = back[c];
    end
  endtask

  function automatic bit model_on(int x, int y);
    return (x >= 80) && (x < 560) && (y >= 0) && (y < 480);
  endfunction

  function automatic int model_sq(int x, int y);
    return (y / 60) * 8 + (x - 80) / 60;
  endfunction

  function automatic int model_addr(int x, int y);
    int p;
    if (!model_on(x, y)) return 0;
    p = mb[model_sq(x, y)];
    if (p == 0) return 0;
    return (p - 1) * 3600 + (y % 60) * 60 + ((x - 80) % 60);
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, bit blk, int cur, bit sv, int ss);
    int sx, sy, sq, p, idx;
    bit border;
    if (!blk) return 12'h000;
    if (!model_on(x, y)) return 12'h222;
    sx = (x - 80) % 60;
    sy = y % 60;
    sq = model_sq(x, y);
    border = (sx < 2) || (sx >= 58) || (sy < 2) || (sy >= 58);
    if (border && sq == cur) return 12'hFF0;
    if (border && sv && sq == ss) return 12'h0F0;
    p = mb[sq];
    if (p != 0) begin
      idx = int'(rom_mem[(p - 1) * 3600 + sy * 60 + sx]);
      if (idx != 0) return pal_mem[idx];
    end
    return (((sq / 8) + (sq % 8)) % 2 == 1) ? 12'h785 : 12'hEED;
  endfunction

  function automatic logic [11:0] rgb_now();
    return {bus.red, bus.green, bus.blue};
  endfunction

  // Holds one pixel for three edges; returns rom_addr after the first and colour after the third.
  task automatic show_pixel(input int x, input int y, input bit blk,
                            output logic [15:0] addr, output logic [11:0] rgb);
    @(negedge clk);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.blank = blk;
    @(negedge clk);
    addr = bus.rom_addr;
    @(negedge clk);
    @(negedge clk);
    rgb = rgb_now();
  endtask

  logic [15:0] a;
  logic [11:0] c;

  initial begin
    for (int i = 0; i < 65536; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++) pal_mem[i] = 12'($urandom);
    pal_mem[5]      = 12'hABC;
    rom_mem[34230]  = 4'd5;   // sq0 (piece 10) texel sx=sy=30
    rom_mem[27030]  = 4'd0;   // sq1 (piece 8) texel sx=sy=30
    model_reset();

    bus.DrawX = '0; bus.DrawY = '0; bus.blank = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sq = '0; bus.wr_piece = '0; bus.clr_board = 1'b0;
    bus.cursor_sq = 6'd63; bus.sel_valid = 1'b0; bus.sel_sq = 6'd0;

    repeat (4) @(negedge clk);
    check_eq("reset_rom_addr", bus.rom_addr, 0);
    check_eq("reset_pal_idx", bus.pal_idx, 0);
    check_eq("reset_rgb", rgb_now(), 0);
    rst = 1'b0;

    show_pixel(80, 0, 1, a, c);
    check_eq("addr_sq0_origin", a, 32400);
    check_eq("rgb_sq0_origin", c, model_rgb(80, 0, 1, 63, 0, 0));
    show_pixel(139, 59, 1, a, c);
    check_eq("addr_sq0_last", a, 35999);
    show_pixel(350, 450, 1, a, c);
    check_eq("addr_sq60_king", a, 19830);

    show_pixel(10, 100, 1, a, c);
    check_eq("off_board_bg", c, 12'h222);
    show_pixel(10, 100, 0, a, c);
    check_eq("off_board_blank", c, 12'h000);

    show_pixel(80, 180, 1, a, c);
    check_eq("empty_dark", c, 12'h785);
    show_pixel(140, 180, 1, a, c);
    check_eq("empty_light", c, 12'hEED);
    show_pixel(170, 30, 1, a, c);
    check_eq("transparent_texel", c, 12'h785);
    show_pixel(110, 30, 1, a, c);
    check_eq("sprite_texel", c, 12'hABC);

    bus.cursor_sq = 6'd0; bus.sel_valid = 1'b1; bus.sel_sq = 6'd0;
    show_pixel(80, 0, 1, a, c);
    check_eq("cursor_over_sel", c, 12'hFF0);
    show_pixel(110, 30, 1, a, c);
    check_eq("cursor_interior", c, 12'hABC);
    bus.cursor_sq = 6'd1;
    show_pixel(80, 0, 1, a, c);
    check_eq("sel_border", c, 12'h0F0);
    bus.cursor_sq = 6'd63; bus.sel_valid = 1'b0;

    // Write at edge k is invisible at k, visible at k+1.
    @(negedge clk);
    bus.DrawX = 10'd290; bus.DrawY = 10'd210;
    bus.wr_en = 1'b1; bus.wr_sq = 6'd27; bus.wr_piece = 4'd5;
    @(negedge clk);
    check_eq("write_same_edge", bus.rom_addr, 0);
    bus.wr_en = 1'b0;
    @(negedge clk);
    check_eq("write_next_edge", bus.rom_addr, 16230);
    mb[27] = 5;
    bus.wr_en = 1'b1; bus.wr_piece = 4'd13;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    check_eq("write_code13_ignored", bus.rom_addr, 16230);

    // clr_board beats wr_en.
    bus.DrawX = 10'd80; bus.DrawY = 10'd0;
    bus.wr_en = 1'b1; bus.wr_sq = 6'd0; bus.wr_piece = 4'd0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    check_eq("write_sq0_empty", bus.rom_addr, 0);
    bus.wr_en = 1'b1; bus.clr_board = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.clr_board = 1'b0;
    @(negedge clk);
    check_eq("clr_over_write", bus.rom_addr, 32400);
    model_reset();

    // Reset mid-stream while a sprite pixel flows.
    bus.DrawX = 10'd110; bus.DrawY = 10'd30;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_rgb", rgb_now(), 12'hABC);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_reset_rgb", rgb_now(), 0);
    check_eq("mid_reset_pal_idx", bus.pal_idx, 0);
    check_eq("mid_reset_rom_addr", bus.rom_addr, 0);
    @(negedge clk);
    check_eq("flush_rgb_1", rgb_now(), 0);
    @(negedge clk);
    check_eq("flush_rgb_2", rgb_now(), 0);
    @(negedge clk);
    check_eq("resume_rgb", rgb_now(), 12'hABC);

    // Randomized stream against the model.
    begin
      logic [11:0] q [$];
      logic [15:0] addr_cur;
      logic [3:0]  pal_cur;
      logic [11:0] e;
      bit          primed;
      int          x, y, cur, ss, wsq, wpc;
      bit          blk, sv;
      addr_cur = '0;
      pal_cur  = '0;
      primed   = 0;
      for (int it = 0; it < 4000; it++) begin
        @(negedge clk);
        if (primed) begin
          check_eq("rnd_rom_addr", bus.rom_addr, addr_cur);
          check_eq("rnd_pal_idx", bus.pal_idx, pal_cur);
          if (q.size() == 3) begin
            e = q.pop_front();
            check_eq("rnd_rgb", rgb_now(), e);
          end
        end
        rst = 1'b0; bus.wr_en = 1'b0; bus.clr_board = 1'b0;
        if ($urandom_range(0, 3) != 0) begin
          x = $urandom_range(80, 559); y = $urandom_range(0, 479);
        end else begin
          x = $urandom_range(0, 799);  y = $urandom_range(0, 524);
        end
        blk = ($urandom_range(0, 9) != 0);
        cur = $urandom_range(0, 63);
        if (model_on(x, y) && $urandom_range(0, 3) == 0) cur = model_sq(x, y);
        sv  = $urandom_range(0, 1) == 1;
        ss  = $urandom_range(0, 63);
        if (model_on(x, y) && $urandom_range(0, 3) == 0) ss = model_sq(x, y);
        bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.blank = blk;
        bus.cursor_sq = 6'(cur); bus.sel_valid = sv; bus.sel_sq = 6'(ss);
        if (it == 0 || $urandom_range(0, 199) == 0) begin
          rst = 1'b1;
          model_reset();
          q.delete();
          repeat (3) q.push_back(12'h000);
          addr_cur = '0;
          pal_cur  = '0;
        end else begin
          q.push_back(model_rgb(x, y, blk, cur, sv, ss));
          pal_cur  = rom_mem[addr_cur];
          addr_cur = 16'(model_addr(x, y));
          wsq = $urandom_range(0, 63);
          wpc = $urandom_range(0, 15);
          if ($urandom_range(0, 3) == 0) begin
            bus.wr_en = 1'b1; bus.wr_sq = 6'(wsq); bus.wr_piece = 4'(wpc);
          end
          if ($urandom_range(0, 49) == 0) bus.clr_board = 1'b1;
          if (bus.clr_board) model_reset();
          else if (bus.wr_en && wpc <= 12) mb[wsq] = wpc;
        end
        primed = 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
